fifo_main_to_cache: RTL
=======================

FIFO_MAIN_TO_CACHE -- requirements
Module: fifo_main_to_cache

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 32, the data and address width.
REQ-002 SHALL have parameter LINE_WORDS, default 8 (power of two, 2..64), the words per cache line.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: cache miss refill request.
REQ-006 SHALL have port req_addr, input, FIFO_WIDTH bits: miss byte address.
REQ-007 SHALL have port req_ready, output, 1 bit: request accepted when both req_valid and req_ready are high.
REQ-008 SHALL have port mem_rd_valid, output, 1 bit: line read command to main memory.
REQ-009 SHALL have port mem_rd_addr, output, FIFO_WIDTH bits: byte address of the first beat.
REQ-010 SHALL have port mem_rd_ready, input, 1 bit: main memory accepts the command.
REQ-011 SHALL have port mem_data_valid, input, 1 bit: a returned data beat, with no backpressure.
REQ-012 SHALL have port mem_data, input, FIFO_WIDTH bits: the returned beat.
REQ-013 SHALL have port fill_valid, output, 1 bit: a word is presented to the cache.
REQ-014 SHALL have port fill_data, output, FIFO_WIDTH bits: the fill word.
REQ-015 SHALL have port fill_addr, output, FIFO_WIDTH bits: the fill word's byte address.
REQ-016 SHALL have port fill_last, output, 1 bit: marks the final word of the line.
REQ-017 SHALL have port fill_ready, input, 1 bit: the cache consumes the word when both fill_valid and fill_ready are high.

Function
REQ-018 SHALL implement FSM states IDLE, CMD and FILL.
REQ-019 SHALL drive req_ready high only in IDLE.
REQ-020 SHALL, on a request handshake, register base = req_addr with the low log2(LINE_WORDS*4) bits cleared, register the word offset (req_addr[log2(LINE_WORDS*4)-1:2]), and go to CMD.
REQ-021 SHALL, in CMD, hold mem_rd_valid high with a stable mem_rd_addr until mem_rd_ready is seen, then go to FILL on the next cycle.
REQ-022 SHALL, in FILL, write each mem_data_valid beat into a LINE_WORDS-entry buffer and increment rx_cnt; fill_valid SHALL rise on the clock edge that captures the beat (one-cycle latency, no combinational bypass).
REQ-023 SHALL drive fill_valid high while fewer words have been sent than received (tx_cnt < rx_cnt), with fill_data taken from buffer[tx_cnt].
REQ-024 SHALL compute fill_addr = base + 4*((start + tx_cnt) mod LINE_WORDS), with the word offset wrapping inside the line.
REQ-025 SHALL assert fill_last when tx_cnt == LINE_WORDS-1.
REQ-026 SHALL return to IDLE on the fill_last handshake and clear both counters.
REQ-027 SHALL allow a write and a read of the buffer in the same cycle, each counter updating independently.
REQ-028 SHALL ignore mem_data_valid outside FILL, and any beat arriving after rx_cnt reaches LINE_WORDS.
REQ-029 SHALL ignore req_valid when not in IDLE; a request presented during the IDLE cycle after line completion SHALL be accepted.
REQ-030 SHALL size counters to log2(LINE_WORDS)+1 bits so that the full-line count is representable.

Reset
REQ-031 SHALL, while rst_n is low, immediately force state IDLE, rx_cnt = tx_cnt = 0, and base/start = 0.
REQ-032 SHALL drive the following reset output values: req_ready = 1, mem_rd_valid = 0, mem_rd_addr = 0, fill_valid = 0, fill_last = 0, fill_addr = 0, fill_data = 0.
REQ-033 SHALL, when reset is asserted mid-line, abandon the line with no further fill beats; buffer contents need not be cleared.

Configuration
REQ-034 SHALL support macro CRITICAL_WORD_FIRST_EN: when it is defined, start = the request word offset and mem_rd_addr = base + 4*start (memory returns beats in wrap order); when it is undefined, start = 0 and mem_rd_addr = base.

Verification
REQ-035 SHALL cover a plain refill: req 0x0000_1014, memory returns 0xA0..0xA7 back-to-back, fill_ready = 1 -> mem_rd_addr 0x1000 (without the macro), fills 0x1000..0x101C carry A0..A7, fill_last on the 8th word, req_ready high the cycle after.
REQ-036 SHALL cover critical word first: the same request with CRITICAL_WORD_FIRST_EN -> mem_rd_addr 0x1014, fill_addr order 0x1014, 0x1018, 0x101C, 0x1000 .. 0x1010.
REQ-037 SHALL cover a stalled cache: fill_ready = 0 for 10 cycles while all 8 beats arrive -> no loss, fill_valid held with word 0 stable, 8 words delivered in order once fill_ready rises.
REQ-038 SHALL cover command backpressure: mem_rd_ready low for 3 cycles -> mem_rd_valid and mem_rd_addr stable, with req_ready low throughout.
REQ-039 SHALL cover spurious beats: mem_data_valid in IDLE, plus a 9th beat -> ignored, with exactly 8 fills.
REQ-040 SHALL cover reset after the 3rd beat: rst_n low for 1 cycle -> outputs at reset values immediately, and a new request completes correctly.

Source files
------------

// File: rtl/fifo_main_to_cache.sv
// fifo_main_to_cache: refill engine moving one cache line from main memory into the cache.
// Define CRITICAL_WORD_FIRST_EN to fetch and deliver the missed word first (wrap order).
module fifo_main_to_cache #(
  parameter int FIFO_WIDTH = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FIFO_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  mem_rd_valid,
  output logic [FIFO_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic                  mem_data_valid,
  input  logic [FIFO_WIDTH-1:0] mem_data,
  output logic                  fill_valid,
  output logic [FIFO_WIDTH-1:0] fill_data,
  output logic [FIFO_WIDTH-1:0] fill_addr,
  output logic                  fill_last,
  input  logic                  fill_ready
);

  localparam int AW = $clog2(LINE_WORDS);
  localparam int CW = AW + 1;
  localparam int OB = AW + 2;
  localparam logic [FIFO_WIDTH-1:0] LMASK =
    FIFO_WIDTH'((LINE_WORDS * 4) - 1);

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    FILL
  } state_e;

  state_e                state_q, state_d;
  logic [FIFO_WIDTH-1:0] base_q, base_d;
  logic [AW-1:0]         start_q, start_d;
  logic [CW-1:0]         rx_q, rx_d;
  logic [CW-1:0]         tx_q, tx_d;
  logic [FIFO_WIDTH-1:0] buf_q [LINE_WORDS];
  logic [AW-1:0]         idx;
  logic                  wr_en;
  logic                  rd_en;

  assign req_ready    = (state_q == IDLE);
  assign mem_rd_valid = (state_q == CMD);
  assign mem_rd_addr  = base_q + (FIFO_WIDTH'(start_q) << 2);

  assign fill_valid = (state_q == FILL) && (tx_q < rx_q);
  assign idx        = start_q + tx_q[AW-1:0];
  assign fill_addr  = base_q + (FIFO_WIDTH'(idx) << 2);
  assign fill_last  = (tx_q == CW'(LINE_WORDS - 1));
  // Gate data so stale buffer contents never leak when idle.
  assign fill_data  = fill_valid ? buf_q[tx_q[AW-1:0]] : '0;

  assign wr_en = (state_q == FILL) && mem_data_valid &&
                 (rx_q < CW'(LINE_WORDS));
  assign rd_en = fill_valid && fill_ready;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    start_d = start_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d  = req_addr & ~LMASK;
          start_d = CWF ? req_addr[OB-1:2] : '0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (mem_rd_ready) state_d = FILL;
      end
      FILL: begin
        if (wr_en) rx_d = rx_q + 1'b1;
        if (rd_en) begin
          tx_d = tx_q + 1'b1;
          if (fill_last) begin
            state_d = IDLE;
            rx_d    = '0;
            tx_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      start_q <= start_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[rx_q[AW-1:0]] <= mem_data;
  end

endmodule
